// File: rtl/mem_bus_scheduler_pkg.sv
// Shared constants and types for the memory bus scheduler.
//   BUS_WIDTH / DATA_WIDTH / RAM_MASK_WIDTH : bus geometry
//   INST_NOP                                : ifetch data driven while no response is routed there
//   PORT_ID_IF / PORT_ID_LS                 : owner tags stored in the in-flight ID FIFO
package mem_bus_scheduler_pkg;
  localparam int BUS_WIDTH      = 32;
  localparam int DATA_WIDTH     = 32;
  localparam int RAM_MASK_WIDTH = 4;

  localparam logic [DATA_WIDTH-1:0] INST_NOP = 32'h0000_0013;

  localparam logic PORT_ID_IF = 1'b0;
  localparam logic PORT_ID_LS = 1'b1;

  // Request as presented to the shared bus.
  typedef struct packed {
    logic                      we;
    logic [BUS_WIDTH-1:0]      addr;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [RAM_MASK_WIDTH-1:0] wmask;
  } bus_req_t;
endpackage

// File: rtl/mem_bus_scheduler_id_fifo.sv
// In-order owner-ID FIFO for accepted-but-unanswered bus requests.
//   clk, rst        : clock, async active-high reset (flushes the FIFO)
//   push, push_id   : enqueue an owner tag (ignored when full)
//   pop             : dequeue the head (ignored when empty)
//   head_id         : owner tag of the oldest in-flight request
//   count/full/empty: occupancy; count disambiguates full from empty
module mem_id_fifo #(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = (AW > 0) ? AW : 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        push_id,
  input  logic        pop,
  output logic        head_id,
  output logic [AW:0] count,
  output logic        full,
  output logic        empty
);
  logic [DEPTH-1:0] slots;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Wrap modulo DEPTH; DEPTH is a power of two but this also covers DEPTH=1.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head_id = slots[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slots  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= push_id;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mem_bus_scheduler.sv
// Arbitrates the ifetch and load/store ports onto one split-transaction bus
// (addr_ok accepts a request, data_ok returns it, strictly in order).
//   clk, rst                 : clock, async active-high reset
//   bus_hold_i               : block new grants; responses still drain
//   if_req/if_addr           : ifetch read request; if_addr_ok/if_data_ok/if_rdata back
//   ls_req/we/addr/wdata/wmask: load/store request; ls_addr_ok/ls_data_ok/ls_rdata back
//   mem_*                    : master side of the shared bus
//   outstanding_o            : in-flight request count
//   proto_err_o              : sticky, set by a response with nothing in flight
module mem_bus_scheduler
  import mem_bus_scheduler_pkg::*;
#(
  parameter  int OUTSTANDING = 2,
  parameter  int STARVE_MAX  = 4,
  localparam int ID_FIFO_AW  = $clog2(OUTSTANDING)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bus_hold_i,
  input  logic                      if_req,
  input  logic [BUS_WIDTH-1:0]      if_addr,
  output logic                      if_addr_ok,
  output logic                      if_data_ok,
  output logic [DATA_WIDTH-1:0]     if_rdata,
  input  logic                      ls_req,
  input  logic                      ls_we,
  input  logic [BUS_WIDTH-1:0]      ls_addr,
  input  logic [DATA_WIDTH-1:0]     ls_wdata,
  input  logic [RAM_MASK_WIDTH-1:0] ls_wmask,
  output logic                      ls_addr_ok,
  output logic                      ls_data_ok,
  output logic [DATA_WIDTH-1:0]     ls_rdata,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [BUS_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [RAM_MASK_WIDTH-1:0] mem_wmask,
  input  logic                      mem_addr_ok,
  input  logic                      mem_data_ok,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic [ID_FIFO_AW:0]       outstanding_o,
  output logic                      proto_err_o
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;
  logic          allowed, starved, gnt_if, gnt_ls;
  logic          push, pop, head_id, fifo_full, fifo_empty;
  bus_req_t      bus_req;

  mem_id_fifo #(.DEPTH(OUTSTANDING)) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_id (gnt_ls ? PORT_ID_LS : PORT_ID_IF),
    .pop     (pop),
    .head_id (head_id),
    .count   (outstanding_o),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Grants are gated by rst so every handshake output reads 0 while reset
  // is held, even if the requesters keep driving. The full check uses the
  // registered count: a pop in the same cycle does not reopen the bus.
  assign allowed = !rst && !bus_hold_i && !fifo_full;
  assign starved = (starve_cnt == SW'(STARVE_MAX));
  assign gnt_if  = allowed && if_req && (starved || !ls_req);
  assign gnt_ls  = allowed && ls_req && !gnt_if;

  always_comb begin
    bus_req = '0;
    if (gnt_ls) begin
      bus_req.we    = ls_we;
      bus_req.addr  = ls_addr;
      bus_req.wdata = ls_wdata;
      bus_req.wmask = ls_wmask;
    end else if (gnt_if) begin
      bus_req.addr  = if_addr;
    end
  end

  assign mem_req    = gnt_if || gnt_ls;
  assign mem_we     = bus_req.we;
  assign mem_addr   = bus_req.addr;
  assign mem_wdata  = bus_req.wdata;
  assign mem_wmask  = bus_req.wmask;

  assign if_addr_ok = gnt_if && mem_addr_ok;
  assign ls_addr_ok = gnt_ls && mem_addr_ok;
  assign push       = mem_req && mem_addr_ok;

  // Responses come back in acceptance order, so the FIFO head names the owner.
  assign pop        = !rst && mem_data_ok && !fifo_empty;
  assign if_data_ok = pop && (head_id == PORT_ID_IF);
  assign ls_data_ok = pop && (head_id == PORT_ID_LS);
  assign if_rdata   = if_data_ok ? mem_rdata : INST_NOP;
  assign ls_rdata   = ls_data_ok ? mem_rdata : '0;

  // Counts cycles ifetch waits while asking; frozen during bus hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!bus_hold_i) begin
      if (!if_req || if_addr_ok) starve_cnt <= '0;
      else if (!starved)         starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            proto_err_o <= 1'b0;
    else if (mem_data_ok && fifo_empty) proto_err_o <= 1'b1;
  end
endmodule
